// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared widths, FSM state encoding and counter helpers for
//               the block-oriented data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int BLOCK_W    = 128;  // one cache block (4 x 32-bit words)
  localparam int BLK_ADDR_W = 28;   // byte address bits [31:4]
  localparam int CNT_W      = 4;    // wide enough for LATENCY-1 up to 14

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmem_state_e;

  // Value loaded into the cycle counter so that BUSY lasts LATENCY posedges.
  function automatic logic [CNT_W-1:0] latency_preload(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_if
// Description : Cache-controller <-> data-memory block bus. The master is
//               the cache controller, the slave is the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_if;
  import dmem_pkg::*;

  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [BLK_ADDR_W-1:0] MEM_BLOCK_ADDR;
  logic [BLOCK_W-1:0]    MEM_WRITEDATA;
  logic [BLOCK_W-1:0]    MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  modport master (
    output MEM_READ,
    output MEM_WRITE,
    output MEM_BLOCK_ADDR,
    output MEM_WRITEDATA,
    input  MEM_READDATA,
    input  MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_READ,
    input  MEM_WRITE,
    input  MEM_BLOCK_ADDR,
    input  MEM_WRITEDATA,
    output MEM_READDATA,
    output MEM_BUSYWAIT
  );

endinterface
`default_nettype wire

// File: rtl/dmem_latency_counter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_latency_counter
// Description : Down-counter timing the busy phase of a memory access.
//               Load has priority over decrement; the count saturates at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_latency_counter
  import dmem_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_val,
  input  wire logic             i_dec,
  output logic                  o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load on access start, otherwise count down towards zero while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Multi-cycle block memory behind a cache controller. An access
//               is latched in IDLE, held in BUSY for LATENCY cycles, and
//               completes with a single DONE cycle before returning to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 5
) (
  input wire logic    CLK,
  input wire logic    RESET,
  data_memory_if.slave bus
);

  localparam int               c_DEPTH   = 1 << ADDR_BITS;
  localparam logic [CNT_W-1:0] c_PRELOAD = latency_preload(LATENCY);

  dmem_state_e          r_state;
  logic                 r_is_write;
  logic [ADDR_BITS-1:0] r_index;
  logic [BLOCK_W-1:0]   r_wdata;
  logic [BLOCK_W-1:0]   r_rdata;

  // Contents start at zero and are deliberately outside the reset domain.
  logic [BLOCK_W-1:0]   r_mem [c_DEPTH] = '{default: '0};

  logic                 w_req;
  logic                 w_accept;
  logic                 w_cnt_zero;
  logic                 w_finish;
  logic                 w_mem_we;
  logic                 w_busywait;
  logic                 w_unused_addr_bits;

  assign w_req    = bus.MEM_READ | bus.MEM_WRITE;
  assign w_accept = (r_state == IDLE) && w_req;
  assign w_finish = (r_state == BUSY) && w_cnt_zero;
  assign w_mem_we = w_finish && r_is_write;

  // Upper block-address bits do not select storage, so addresses alias.
  assign w_unused_addr_bits = ^bus.MEM_BLOCK_ADDR[BLK_ADDR_W-1:ADDR_BITS];

  dmem_latency_counter u_cnt (
    .clk        (CLK),
    .rst        (RESET),
    .i_load     (w_accept),
    .i_load_val (c_PRELOAD),
    .i_dec      (r_state == BUSY),
    .o_zero     (w_cnt_zero)
  );

  // Access sequencing: latch request in IDLE, complete in BUSY, one DONE cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_is_write <= 1'b0;
      r_index    <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // Read and write together is resolved as a write.
            r_is_write <= bus.MEM_WRITE;
            r_index    <= bus.MEM_BLOCK_ADDR[ADDR_BITS-1:0];
            r_wdata    <= bus.MEM_WRITEDATA;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (w_cnt_zero) begin
            if (!r_is_write) begin
              r_rdata <= r_mem[r_index];
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Storage write at the end of a write access; a reset forces IDLE first,
  // so an aborted write never reaches this port.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  // Stall the requester in the same cycle it asks; release only in DONE.
  always_comb begin
    w_busywait = 1'b0;
    case (r_state)
      IDLE:    w_busywait = w_req;
      BUSY:    w_busywait = 1'b1;
      DONE:    w_busywait = 1'b0;
      default: w_busywait = 1'b0;
    endcase
  end

  assign bus.MEM_READDATA = r_rdata;
  assign bus.MEM_BUSYWAIT = w_busywait;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory: table of directed block
//               accesses, hand-written multi-cycle sequences, and randomized
//               accesses scored against a transaction-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  localparam int L     = 5;
  localparam int ABITS = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  data_memory_if bus_if ();

  data_memory #(
    .ADDR_BITS (ABITS),
    .LATENCY   (L)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-block storage plus the last value a read returned.
  logic [127:0] m_mem [1 << ABITS];
  logic [127:0] m_rd;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wd;
    logic [127:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  localparam logic [127:0] c_A5  = {16{8'hA5}};
  localparam logic [127:0] c_PAT = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One completed transaction as seen by the cache controller.
  task automatic model_apply(input logic rd, input logic wr, input logic [27:0] addr,
                             input logic [127:0] wd);
    if (wr)      m_mem[addr[ABITS-1:0]] = wd;
    else if (rd) m_rd = m_mem[addr[ABITS-1:0]];
  endtask

  task automatic idle_inputs();
    bus_if.MEM_READ       = 1'b0;
    bus_if.MEM_WRITE      = 1'b0;
    bus_if.MEM_BLOCK_ADDR = '0;
    bus_if.MEM_WRITEDATA  = '0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wd);
    bus_if.MEM_READ       = rd;
    bus_if.MEM_WRITE      = wr;
    bus_if.MEM_BLOCK_ADDR = addr;
    bus_if.MEM_WRITEDATA  = wd;
  endtask

  // Count negedges with BUSYWAIT high until it drops; bounded.
  task automatic wait_low(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus_if.MEM_BUSYWAIT !== 1'b1) break;
      n++;
      if (n > 40) begin
        n_vec++;
        n_err++;
        $display("FAIL busy_timeout: busywait still high after %0d cycles, required low", n);
        break;
      end
    end
  endtask

  // Single access from IDLE; optionally scrambles inputs while busy.
  task automatic access(input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] wd, input bit scramble,
                        output logic [127:0] rdata);
    int n;
    @(negedge clk);
    drive(rd, wr, addr, wd);
    #1 chk("bw_on_request", {127'd0, bus_if.MEM_BUSYWAIT}, 128'd1);
    @(posedge clk);
    model_apply(rd, wr, addr, wd);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus_if.MEM_BUSYWAIT !== 1'b1) break;
      n++;
      if (scramble)
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 28'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
      else
        idle_inputs();
      if (n > 40) begin
        n_vec++;
        n_err++;
        $display("FAIL busy_timeout: busywait still high after %0d cycles, required low", n);
        break;
      end
    end
    chk("busy_len", 128'(n), 128'(L));
    idle_inputs();
    rdata = bus_if.MEM_READDATA;
    @(posedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rdat;
    logic [127:0] d0;
    logic [127:0] d1;
    int           n;

    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < (1 << ABITS); i++) m_mem[i] = '0;
    m_rd = '0;

    tbl[0] = '{1'b0, 1'b1, 28'h0000003,   c_A5,   128'd0};
    tbl[1] = '{1'b1, 1'b0, 28'h0000003,   128'd0, c_A5};
    tbl[2] = '{1'b0, 1'b1, 28'h0000007,   c_PAT,  c_A5};
    tbl[3] = '{1'b1, 1'b0, 28'h0000007,   128'd0, c_PAT};
    tbl[4] = '{1'b1, 1'b0, 28'h0000107,   128'd0, c_PAT};
    tbl[5] = '{1'b1, 1'b1, 28'h0000004,   128'd1, c_PAT};
    tbl[6] = '{1'b1, 1'b0, 28'h0000004,   128'd0, 128'd1};
    tbl[7] = '{1'b1, 1'b0, 28'hFFFFF04,   128'd0, 128'd1};
    tbl[8] = '{1'b1, 1'b0, 28'h00000C8,   128'd0, 128'd0};

    // ---- reset behaviour ----
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busywait", {127'd0, bus_if.MEM_BUSYWAIT}, 128'd0);
    chk("rst_readdata", bus_if.MEM_READDATA, 128'd0);
    bus_if.MEM_READ = 1'b1;
    #1 chk("rst_bw_follows_req", {127'd0, bus_if.MEM_BUSYWAIT}, 128'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1 chk("rst_no_accept_now", {127'd0, bus_if.MEM_BUSYWAIT}, 128'd0);
    @(negedge clk);
    chk("rst_no_accept_next", {127'd0, bus_if.MEM_BUSYWAIT}, 128'd0);

    // ---- directed table ----
    for (int i = 0; i < 9; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, 1'b0, rdat);
      chk($sformatf("tbl%0d_readdata", i), rdat, tbl[i].exp_rd);
    end

    // ---- eviction: write held until release, then read next cycle ----
    for (int k = 0; k < 2; k++) begin
      d0 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      drive(1'b0, 1'b1, 28'd10, d0);
      @(posedge clk);
      model_apply(1'b0, 1'b1, 28'd10, d0);
      wait_low(n);
      chk("evict_wr_busy_len", 128'(n), 128'(L));
      chk("evict_wr_keeps_rd", bus_if.MEM_READDATA, m_rd);
      drive(1'b1, 1'b0, (k == 0) ? 28'd11 : 28'd10, '0);
      wait_low(n);
      chk("evict_rd_busy_len", 128'(n), 128'(L + 1));
      model_apply(1'b1, 1'b0, (k == 0) ? 28'd11 : 28'd10, '0);
      idle_inputs();
      chk("evict_rd_data", bus_if.MEM_READDATA, m_rd);
      @(posedge clk);
    end

    // ---- read held high through DONE: one access per interval ----
    @(negedge clk);
    drive(1'b1, 1'b0, 28'd3, '0);
    @(posedge clk);
    model_apply(1'b1, 1'b0, 28'd3, '0);
    wait_low(n);
    chk("hold_first_len", 128'(n), 128'(L));
    chk("hold_first_data", bus_if.MEM_READDATA, c_A5);
    wait_low(n);
    chk("hold_reaccept_len", 128'(n), 128'(L + 1));
    idle_inputs();
    chk("hold_second_data", bus_if.MEM_READDATA, c_A5);
    @(posedge clk);

    // ---- reset during a write to index 9 ----
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = ~d0;
    access(1'b0, 1'b1, 28'd9, d0, 1'b0, rdat);
    @(negedge clk);
    drive(1'b0, 1'b1, 28'd9, d1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    idle_inputs();
    m_rd = '0;
    #1 chk("abort_bw_idle", {127'd0, bus_if.MEM_BUSYWAIT}, 128'd0);
    bus_if.MEM_READ = 1'b1;
    #1 chk("abort_bw_follows", {127'd0, bus_if.MEM_BUSYWAIT}, 128'd1);
    chk("abort_rd_cleared", bus_if.MEM_READDATA, 128'd0);
    bus_if.MEM_READ = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 28'd9, '0, 1'b0, rdat);
    chk("abort_mem9_kept", rdat, d0);

    // ---- randomized accesses vs. model ----
    for (int i = 0; i < 40; i++) begin
      int           op;
      logic [27:0]  a;
      logic [127:0] w;
      logic         rd;
      logic         wr;
      op = $urandom_range(0, 3);
      a  = {20'($urandom), 8'($urandom_range(0, 15))};
      w  = {$urandom, $urandom, $urandom, $urandom};
      rd = (op == 0) || (op == 2) || (op == 3);
      wr = (op == 1) || (op == 2);
      access(rd, wr, a, w, 1'($urandom_range(0, 1)), rdat);
      chk($sformatf("rand%0d_readdata", i), rdat, m_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameters SHALL be:
- ADDR_BITS, default 8: number of block-address bits used to index storage, giving 2^ADDR_BITS blocks.
- LATENCY, default 5: busy cycles per access; legal range 1..15.
REQ-002 Ports SHALL be:
- CLK  input  1  single clock; rising edge active.
- RESET  input  1  asynchronous, active-high reset.
- MEM_READ  input  1  block read request from the cache controller.
- MEM_WRITE  input  1  block write request from the cache controller.
- MEM_BLOCK_ADDR  input  28  block address (byte address bits [31:4]).
- MEM_WRITEDATA  input  128  block to store; word0 in bits [31:0].
- MEM_READDATA  output  128  fetched block.
- MEM_BUSYWAIT  output  1  high while an access is pending or in progress.
REQ-003 One clock, CLK; reset is asynchronous and active-high on RESET.

Function
REQ-004 Storage SHALL be 2^ADDR_BITS entries x 128 bits, indexed by MEM_BLOCK_ADDR[ADDR_BITS-1:0]; upper address bits SHALL be ignored, so addresses alias.
REQ-005 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-006 IDLE: MEM_BUSYWAIT SHALL equal (MEM_READ | MEM_WRITE) combinationally, so the requester stalls in the same cycle it asserts a request.
REQ-007 IDLE with a request at a posedge:
- latch operation, index and write data;
- load the cycle counter with LATENCY-1;
- go to BUSY.
REQ-008 BUSY: MEM_BUSYWAIT=1; the counter decrements each posedge.
REQ-009 BUSY, at the posedge where the counter is 0:
- write: latched data is stored at the latched index;
- read: MEM_READDATA is loaded from the latched index;
- state goes to DONE.
REQ-010 DONE SHALL last exactly one cycle with MEM_BUSYWAIT=0 and MEM_READDATA held; requests are ignored in DONE; the state then returns to IDLE.
REQ-011 Timing: a request sampled at posedge t0 SHALL see MEM_BUSYWAIT fall after posedge t0+LATENCY, and a new request is accepted no earlier than posedge t0+LATENCY+2.
REQ-012 Inputs changing during BUSY or DONE SHALL have no effect; the latched values are used.
REQ-013 MEM_READ and MEM_WRITE both high in IDLE SHALL be treated as a write.
REQ-014 MEM_READDATA SHALL hold its last loaded value until the next completed read; a write SHALL NOT change it.
REQ-015 Back-to-back write then read (dirty eviction): the read issued after DONE SHALL be accepted in IDLE and SHALL return the just-written block if the indices match.

Reset
REQ-016 While RESET is high:
- state=IDLE, counter=0, MEM_READDATA=0;
- MEM_BUSYWAIT follows REQ-006, but no request is accepted.
REQ-017 RESET mid-access SHALL abort the access; a pending write SHALL NOT modify storage.
REQ-018 Storage contents SHALL be zero at time zero and SHALL NOT be altered by RESET.

Structure
REQ-019 The shared package dmem_pkg SHALL hold:
- BLOCK_W=128 and BLK_ADDR_W=28;
- the state encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
REQ-020 One sub-module, dmem_latency_counter (load, decrement, zero flag), is natural; storage and the FSM stay in data_memory.

Verification
REQ-021 Read with LATENCY=5, storage[3]=128'hA5..A5, MEM_READ=1, addr=3 at t0 -> BUSYWAIT high immediately and through posedge t0+5, then low for 1 cycle with READDATA=128'hA5..A5.
REQ-022 Write 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 to addr 7, then read addr 7 -> READDATA equals the written value; addr 0x107 (aliased) also returns it.
REQ-023 Eviction sequence: MEM_WRITE held until BUSYWAIT falls, then MEM_READ to a different index in the next cycle -> second access accepted after DONE with no lost or repeated access.
REQ-024 RESET pulsed at t0+2 during a write to addr 9 -> FSM IDLE, BUSYWAIT follows requests, storage[9] unchanged.
REQ-025 MEM_READ=MEM_WRITE=1, addr 4, data 128'h1 -> storage[4]=1; READDATA unchanged from its previous value.
REQ-026 MEM_READ held high through DONE -> exactly one access performed; re-acceptance only at the posedge after DONE.
